gpio_port: RTL
==============

# gpio_port

Parametrised general-purpose I/O peripheral on the RISC5 I/O bus, replacing the fixed 8-bit gpout/gpoc register pair in the top level. Provides W pins with per-bit direction, atomic set/clear/toggle of outputs, two-flop input synchronisation, and per-bit rising/falling edge capture with an interrupt line. It sits behind the top-level I/O decoder, and its pad_out/pad_oe outputs drive IOBUFs instantiated in the top level.

## Interface
- W, 8, number of pins, 1..32
- SYNC_STAGES, 2, input synchroniser depth, 2..4
- DEB_CYCLES, 16, debounce stability length in clocks, 2..65535 (used only with GPIO_DEBOUNCE_EN)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sel  in  1  block selected (decoder: ioenb and address in the block's 8-word window)
- wadr  in  3  word offset within the window
- wr  in  1  write strobe, one cycle per access
- rd  in  1  read strobe (no side effects; for bench/trace only)
- wdata  in  32  write data (outbus)
- rdata  out  32  read data, combinational from wadr and registers; unused upper bits read 0
- pad_in  in  W  pin input (from IOBUF O)
- pad_out  out  W  pin output value (to IOBUF I)
- pad_oe  out  W  output enable, 1 = drive (top level drives IOBUF T with ~pad_oe)
- irq  out  1  OR of enabled pending edge flags

## Operation
- Register map (writes act when sel & wr; wadr selects):
  - 0 DATA: read returns the filtered input; write loads OUT = wdata[W-1:0]
  - 1 OE: read/write direction register
  - 2 SET: write OUT |= wdata; read returns OUT
  - 3 CLR: write OUT &= ~wdata; read returns OUT
  - 4 TGL: write OUT ^= wdata; read returns OUT
  - 5 RISE: rising-edge capture enable per bit, read/write
  - 6 FALL: falling-edge capture enable per bit, read/write
  - 7 STAT: read returns pending flags; write 1 clears a bit, 0 leaves it unchanged
- Input path: pad_in → SYNC_STAGES flops → optional debounce → filtered value `fin` → one-cycle delayed copy `fprev`.
- Edge events: rise = fin & ~fprev & RISE; fall = ~fin & fprev & FALL; STAT |= rise | fall each cycle.
- irq = |STAT, driven combinationally from registers (a flag is pending only if its capture was enabled).
- pad_out = OUT and pad_oe = OE, both driven directly from registers. Pins with OE = 1 still read back through the input path.
- Reset: OUT = 0, OE = 0 (all inputs), RISE = FALL = 0, STAT = 0, synchroniser/fin/fprev = 0, debounce counters = 0. Consequences: pad_out = 0, pad_oe = 0, irq = 0, rdata reflects the reset register values.
- Boundary conditions:
  - A W1C write to a STAT bit and a new event on the same bit in the same cycle: the event wins, so the bit stays 1.
  - Clearing a RISE/FALL bit does not clear an already-pending STAT bit.
  - Writes to offsets with W < 32 ignore wdata[31:W].
  - An asynchronous reset mid-debounce discards the partial count.

## Timing
- OUT/OE/RISE/FALL/STAT update on the clk edge ending the write cycle; pad_out/pad_oe change in the same cycle as the register.
- Input latency without debounce: a pin stable before edge k reads back on DATA after edge k+SYNC_STAGES−1. STAT and irq assert after edge k+SYNC_STAGES.
- With debounce, add DEB_CYCLES clocks to both figures.
- Every cycle in which the register holds a flag that the bench clears with W1C, irq is low on the cycle after the clearing edge, unless a new event wins.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Each bit has a counter of clog2(DEB_CYCLES) bits.
  - fin takes the synchronised value only after it has differed from fin for DEB_CYCLES consecutive clocks.
  - Any return to the fin value resets the counter to 0, so glitches shorter than DEB_CYCLES are invisible.
- Not defined: fin is the synchroniser output, no counters are instantiated, and DEB_CYCLES is ignored.

## Structure
- Package gpio_pkg: register offset constants (GPIO_DATA=0 … GPIO_STAT=7) and a localparam for the maximum W (32); shared with firmware headers.
- Sub-module gpio_in_filter: one per bit via generate; contains the synchroniser, the optional debounce counter, and the fin/fprev flops; outputs fin, rise_raw and fall_raw.
- The top module holds the register file, the STAT update logic and the read mux.

## Test plan
- Reset, then write OE=0xFF and DATA=0xA5, SET 0x0A, CLR 0x81, TGL 0x03 → OUT reads 0xA5, 0xAF, 0x2E, 0x2D in turn; pad_out matches each value and pad_oe=0xFF.
- RISE=0x01, pad_in[0] goes 0→1 before edge k (SYNC_STAGES=2, no debounce) → DATA bit0=1 after edge k+1, STAT=0x01 and irq=1 after edge k+2.
- Pending STAT=0x01, W1C 0x01 in the same cycle as a new rising event on bit 0 → STAT stays 0x01; a W1C in a later quiet cycle → STAT=0, irq=0.
- FALL=0x80, RISE=0: toggle pad_in[7] 1→0→1 → only one STAT bit7 set; the 0→1 edge sets nothing.
- With GPIO_DEBOUNCE_EN and DEB_CYCLES=16: a 10-cycle glitch on pad_in[3] → DATA and STAT unchanged; a 20-cycle level → DATA bit3 changes exactly 16 clocks after the synchroniser output.
- W=32: write 0xFFFF_FFFF to OE, then assert rst mid-transfer → all outputs 0 immediately (asynchronously), and all registers read 0 after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and size limits for the gpio_port peripheral.
// Shared with firmware headers, so offsets must stay stable.
package gpio_pkg;

  localparam int GPIO_MAX_W = 32;

  localparam logic [2:0] GPIO_DATA = 3'd0;
  localparam logic [2:0] GPIO_OE   = 3'd1;
  localparam logic [2:0] GPIO_SET  = 3'd2;
  localparam logic [2:0] GPIO_CLR  = 3'd3;
  localparam logic [2:0] GPIO_TGL  = 3'd4;
  localparam logic [2:0] GPIO_RISE = 3'd5;
  localparam logic [2:0] GPIO_FALL = 3'd6;
  localparam logic [2:0] GPIO_STAT = 3'd7;

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin input conditioning.
// Synchroniser chain, optional debounce (GPIO_DEBOUNCE_EN), then the
// filtered value fin and its one-cycle delayed copy used for edge detection.
module gpio_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic fin_o,
  output logic rise_raw_o,
  output logic fall_raw_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   fin_s;
  logic                   fprev_q;

  // Shift the raw pin through the metastability synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_q, fin_d;

  // Accept a new level only after it has differed from fin for DEB_CYCLES clocks
  always_comb begin
    cnt_d = '0;
    fin_d = fin_q;
    if (sync_s != fin_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        fin_d = sync_s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state; async reset discards any partial count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      fin_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fin_q <= fin_d;
    end
  end

  assign fin_s = fin_q;
`else
  assign fin_s = sync_s;
`endif

  // Remember last cycle's filtered value for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fprev_q <= 1'b0;
    else      fprev_q <= fin_s;
  end

  assign fin_o      = fin_s;
  assign rise_raw_o = fin_s & ~fprev_q;
  assign fall_raw_o = ~fin_s & fprev_q;

endmodule

// File: rtl/gpio_port.sv
// gpio_port: W-pin GPIO with direction, atomic set/clear/toggle, and
// enabled rising/falling edge capture into W1C pending flags driving irq.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [2:0]   wadr,
  input  logic         wr,
  input  logic         rd,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  input  logic [W-1:0] pad_in,
  output logic [W-1:0] pad_out,
  output logic [W-1:0] pad_oe,
  output logic         irq
);

  logic [W-1:0] out_q,  out_d;
  logic [W-1:0] oe_q,   oe_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;
  logic [W-1:0] stat_q, stat_d;
  logic [W-1:0] w1c_s;
  logic [W-1:0] fin_s, rise_raw_s, fall_raw_s;
  logic [W-1:0] wd_s;
  logic         wr_en_s;
  logic         unused_bits_s;

  // Read strobe has no side effects and upper write bits are dropped
  assign unused_bits_s = ^{rd, wdata};

  assign wr_en_s = sel & wr;
  assign wd_s    = wdata[W-1:0];

  for (genvar i = 0; i < W; i++) begin : g_in
    gpio_in_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .pad_i     (pad_in[i]),
      .fin_o     (fin_s[i]),
      .rise_raw_o(rise_raw_s[i]),
      .fall_raw_o(fall_raw_s[i])
    );
  end

  // Register-file write decode and pending-flag update (new events beat W1C)
  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c_s  = '0;
    if (wr_en_s) begin
      case (wadr)
        GPIO_DATA: out_d  = wd_s;
        GPIO_OE:   oe_d   = wd_s;
        GPIO_SET:  out_d  = out_q | wd_s;
        GPIO_CLR:  out_d  = out_q & ~wd_s;
        GPIO_TGL:  out_d  = out_q ^ wd_s;
        GPIO_RISE: rise_d = wd_s;
        GPIO_FALL: fall_d = wd_s;
        GPIO_STAT: w1c_s  = wd_s;
        default:   w1c_s  = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    stat_d = (stat_q & ~w1c_s) | (rise_raw_s & rise_q) | (fall_raw_s & fall_q);
  end

  // Register file state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      oe_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stat_q <= stat_d;
    end
  end

  // Read mux; bits above W read as zero
  always_comb begin
    rdata = '0;
    case (wadr)
      GPIO_DATA: rdata[W-1:0] = fin_s;
      GPIO_OE:   rdata[W-1:0] = oe_q;
      GPIO_SET,
      GPIO_CLR,
      GPIO_TGL:  rdata[W-1:0] = out_q;
      GPIO_RISE: rdata[W-1:0] = rise_q;
      GPIO_FALL: rdata[W-1:0] = fall_q;
      GPIO_STAT: rdata[W-1:0] = stat_q;
      default:   rdata        = '0;
    endcase
  end

  assign pad_out = out_q;
  assign pad_oe  = oe_q;
  assign irq     = |stat_q;

endmodule
